lut_func_engine: RTL and testbench
==================================

LUT_FUNC_ENGINE -- requirements
Module: lut_func_engine

Interface
REQ-001 SHALL have parameter N_IN, default 4, meaning number of function inputs (2..8).
REQ-002 SHALL have parameter N_OUT, default 6, meaning number of function outputs (1..16).
REQ-003 SHALL have parameter CNT_W, default 32, meaning width of the result counter.
REQ-004 Port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port cfg_valid, input, 1 bit: truth-table write request.
REQ-007 Port cfg_ready, output, 1 bit: write can be accepted.
REQ-008 Port cfg_idx, input, clog2(N_OUT) bits: output index to program.
REQ-009 Port cfg_tt, input, 2^N_IN bits: truth table; bit k is f(x=k), x0 = LSB of k.
REQ-010 Port in_valid / in_ready, input / output, 1 bit each: input-vector handshake.
REQ-011 Port in_x, input, N_IN bits: input vector.
REQ-012 Port sweep_start, input, 1 bit: one-cycle pulse requesting an exhaustive sweep.
REQ-013 Port out_valid / out_ready, output / input, 1 bit each: result handshake.
REQ-014 Port out_f, output, N_OUT bits: out_f[j] = table j at the evaluated vector.
REQ-015 Port out_x, output, N_IN bits: the vector that produced out_f.
REQ-016 Port out_last, output, 1 bit: high on the final result of a sweep only.
REQ-017 Port busy, output, 1 bit: high when the FSM is not IDLE.
REQ-018 Port eval_cnt, output, CNT_W bits: completed output handshakes, wrapping modulo 2^CNT_W.

Function
REQ-019 FSM states SHALL be IDLE, STREAM and SWEEP.
REQ-020 IDLE->SWEEP on sweep_start with the result register empty; IDLE->STREAM on an accepted in_valid; STREAM->IDLE when the result register empties with no new accept; SWEEP->IDLE on the handshake of the out_last result.
REQ-021 sweep_start SHALL be ignored in STREAM and SWEEP, and in IDLE while out_valid=1.
REQ-022 in_ready SHALL be (state!=SWEEP) && (!out_valid || out_ready).
REQ-023 A vector accepted in cycle N SHALL appear on out_f/out_x with out_valid=1 in cycle N+1.
REQ-024 out_f/out_x/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 Full throughput SHALL be one result per cycle with out_ready held high.
REQ-026 In SWEEP the internal generator SHALL issue vectors 0,1,...,2^N_IN-1 in order under the same backpressure rule; out_last SHALL be set for vector 2^N_IN-1.
REQ-027 The sweep counter SHALL be N_IN+1 bits wide so that the terminal count does not alias to 0.
REQ-028 cfg_ready SHALL be (state==IDLE) && !out_valid; a write is accepted when cfg_valid && cfg_ready.
REQ-029 A write to cfg_idx >= N_OUT SHALL be accepted and discarded.
REQ-030 A table write SHALL take effect for the first vector accepted after the write cycle.
REQ-031 If cfg_valid and in_valid are both high in IDLE, cfg SHALL win; in_ready SHALL be 0 that cycle.
REQ-032 eval_cnt SHALL increment on every out_valid && out_ready cycle, in both modes.

Reset
REQ-033 On rst_n=0, state SHALL be IDLE, all truth tables 0, and out_valid, out_last, busy, out_f, out_x and eval_cnt 0.
REQ-034 Reset mid-sweep or mid-stream SHALL drop the in-flight result with no out_last; cfg_ready SHALL be 1 on the first cycle after deassertion.

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the N_IN/N_OUT range-check constants.
REQ-036 A single sub-module lut_func_table (N_OUT tables of 2^N_IN bits, write port, combinational read) SHALL be instantiated; the FSM, sweep counter and result register stay in the top level.

Verification
REQ-037 Defaults: write idx1 = 0x0FF0 (x2^x3), then stream x=4 -> next cycle out_f[1]=1, out_x=4; stream x=12 -> out_f[1]=0.
REQ-038 Backpressure: stream x=5 with out_ready=0 for 3 cycles -> in_ready=0, out_f/out_x held; release -> eval_cnt=1.
REQ-039 Sweep: idx0 = 0xAAAA, pulse sweep_start, out_ready=1 -> 16 results, out_f[0] = x0, out_last only on x=15, busy 1 then 0, eval_cnt=16.
REQ-040 Simultaneous cfg_valid and in_valid in IDLE -> write accepted, vector stalled one cycle and then evaluated with the new table.
REQ-041 Reset asserted at sweep vector 7 -> all tables 0, out_valid=0, eval_cnt=0, no out_last; a new sweep restarts at 0.
REQ-042 cfg_idx=7 with N_OUT=6 -> write accepted and discarded; tables 0..5 unchanged.

Source files
------------

// File: rtl/lut_func_engine_pkg.sv
// Shared types and parameter limits for the LUT function engine.
package lut_func_engine_pkg;

  // Supported range of the engine's parameters.
  localparam int N_IN_MIN  = 2;
  localparam int N_IN_MAX  = 8;
  localparam int N_OUT_MIN = 1;
  localparam int N_OUT_MAX = 16;

  // Top-level control state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_SWEEP  = 2'd2
  } state_e;

  // Width of the table-select index; a single table still gets a 1-bit index.
  function automatic int idx_w(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

  // True when both parameters sit inside the supported range.
  function automatic bit params_ok(input int n_in, input int n_out);
    return (n_in >= N_IN_MIN) && (n_in <= N_IN_MAX) &&
           (n_out >= N_OUT_MIN) && (n_out <= N_OUT_MAX);
  endfunction

endpackage

// File: rtl/lut_func_table.sv
// Truth-table store: N_OUT tables of 2^N_IN bits each, one write port and
// a combinational read of every table at a single input vector.
module lut_func_table
  import lut_func_engine_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [idx_w(N_OUT)-1:0]   wr_idx,
  input  logic [(1 << N_IN)-1:0]    wr_tt,
  input  logic [N_IN-1:0]           rd_x,
  output logic [N_OUT-1:0]          rd_f
);

  localparam int IDX_W = idx_w(N_OUT);
  localparam int DEPTH = 1 << N_IN;

  logic [DEPTH-1:0] tt_mem [N_OUT];

  // Table storage; an index that matches no table simply writes nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_OUT; j++) begin
        tt_mem[j] <= '0;
      end
    end else if (wr_en) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (wr_idx == IDX_W'(j)) begin
          tt_mem[j] <= wr_tt;
        end
      end
    end
  end

  // Bit k of table j is f_j(x = k).
  always_comb begin
    rd_f = '0;
    for (int j = 0; j < N_OUT; j++) begin
      rd_f[j] = tt_mem[j][rd_x];
    end
  end

endmodule

// File: rtl/lut_func_engine.sv
// LUT function engine: evaluates N_OUT programmable boolean functions of an
// N_IN-bit vector, either per streamed vector or as an exhaustive sweep.
//
// Handshakes: a transfer on any valid/ready pair happens in the cycle where
// both are high at the rising clock edge. valid never depends on ready.
// While out_valid is high and out_ready low, out_f/out_x/out_last hold.
// cfg_valid has priority over in_valid in IDLE (in_ready drops that cycle).
module lut_func_engine
  import lut_func_engine_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 6,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [idx_w(N_OUT)-1:0]   cfg_idx,
  input  logic [(1 << N_IN)-1:0]    cfg_tt,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN-1:0]           in_x,
  input  logic                      sweep_start,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT-1:0]          out_f,
  output logic [N_IN-1:0]           out_x,
  output logic                      out_last,
  output logic                      busy,
  output logic [CNT_W-1:0]          eval_cnt,
  output state_e                    dbg_state
);

  localparam int            DEPTH  = 1 << N_IN;
  // Sweep counter is one bit wider so "all vectors issued" (DEPTH) is
  // distinct from vector 0.
  localparam logic [N_IN:0] LAST_X = (N_IN + 1)'(DEPTH - 1);

  if (!params_ok(N_IN, N_OUT)) begin : g_param_check
    $error("lut_func_engine: N_IN must be 2..8 and N_OUT must be 1..16");
  end

  state_e           state;
  state_e           state_nxt;
  logic [N_IN:0]    sweep_cnt;

  logic             load_ok;
  logic             cfg_fire;
  logic             in_fire;
  logic             out_fire;
  logic             sweep_go;
  logic             gen_fire;
  logic             ld;
  logic             ld_last;
  logic [N_IN-1:0]  rd_x;
  logic [N_OUT-1:0] rd_f;

  // Handshake decode and selection of the vector being evaluated.
  always_comb begin
    load_ok   = !out_valid || out_ready;
    cfg_ready = (state == ST_IDLE) && !out_valid;
    cfg_fire  = cfg_valid && cfg_ready;
    in_ready  = (state != ST_SWEEP) && load_ok && !cfg_fire;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    // A sweep needs an empty result register; a coinciding table write or
    // accepted vector takes precedence and the pulse is dropped.
    sweep_go  = sweep_start && (state == ST_IDLE) && !out_valid &&
                !cfg_fire && !in_fire;
    gen_fire  = (state == ST_SWEEP) && load_ok && !sweep_cnt[N_IN];
    if (state == ST_SWEEP) begin
      rd_x = sweep_cnt[N_IN-1:0];
    end else if (sweep_go) begin
      rd_x = '0;
    end else begin
      rd_x = in_x;
    end
    ld      = in_fire || gen_fire || sweep_go;
    ld_last = gen_fire && (sweep_cnt == LAST_X);
  end

  // Next-state logic for the IDLE/STREAM/SWEEP controller.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (sweep_go) begin
          state_nxt = ST_SWEEP;
        end else if (in_fire) begin
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (!in_fire && (out_fire || !out_valid)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (out_fire && out_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sweep generator: vector 0 issues on the start edge, then one per load slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt <= '0;
    end else if (sweep_go) begin
      sweep_cnt <= (N_IN + 1)'(1);
    end else if (gen_fire) begin
      sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  // Result register: loads on any issued vector, empties on an output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_f     <= '0;
      out_x     <= '0;
      out_last  <= 1'b0;
    end else if (ld) begin
      out_valid <= 1'b1;
      out_f     <= rd_f;
      out_x     <= rd_x;
      out_last  <= ld_last;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Count of completed output transfers, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_cnt <= '0;
    end else if (out_fire) begin
      eval_cnt <= eval_cnt + 1'b1;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  lut_func_table #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (cfg_fire),
    .wr_idx (cfg_idx),
    .wr_tt  (cfg_tt),
    .rd_x   (rd_x),
    .rd_f   (rd_f)
  );

endmodule

// File: tb/tb_lut_func_engine.sv
// Self-checking bench for lut_func_engine with a queue-based reference model.
module tb_lut_func_engine;
  import lut_func_engine_pkg::*;

  localparam int N_IN  = 4;
  localparam int N_OUT = 6;
  localparam int CNT_W = 32;
  localparam int DEPTH = 1 << N_IN;
  localparam int EW    = 1 + N_IN + N_OUT;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        cfg_idx;
  logic [DEPTH-1:0]  cfg_tt;
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_x;
  logic              sweep_start;
  logic              out_valid;
  logic              out_ready;
  logic [N_OUT-1:0]  out_f;
  logic [N_IN-1:0]   out_x;
  logic              out_last;
  logic              busy;
  logic [CNT_W-1:0]  eval_cnt;
  state_e            dbg_state;

  lut_func_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_tt(cfg_tt),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .sweep_start(sweep_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_x(out_x),
    .out_last(out_last), .busy(busy), .eval_cnt(eval_cnt), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Entry layout: {last, x, f}. Each function is just a lookup of its table.
  logic [DEPTH-1:0] m_tt [N_OUT];
  logic [EW-1:0]    exp_q[$];
  int unsigned      m_cnt  = 0;
  bit               m_sweep = 0;

  function automatic logic [N_OUT-1:0] model_f(input logic [N_IN-1:0] x);
    logic [N_OUT-1:0] f;
    for (int j = 0; j < N_OUT; j++) f[j] = m_tt[j][x];
    return f;
  endfunction

  // Inputs change only just after posedge, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    logic          m_ov;
    logic          m_cfg_ready;
    logic          m_in_ready;
    logic [EW-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt   = 0;
      m_sweep = 0;
      for (int j = 0; j < N_OUT; j++) m_tt[j] = '0;
    end else begin
      m_ov        = (exp_q.size() != 0);
      m_cfg_ready = !m_ov;
      m_in_ready  = !m_sweep && (!m_ov || out_ready) && !(cfg_valid && m_cfg_ready);
      check("mon_out_valid", out_valid, m_ov);
      check("mon_cfg_ready", cfg_ready, m_cfg_ready);
      check("mon_in_ready", in_ready, m_in_ready);
      check("mon_busy", busy, m_ov);
      check("mon_eval_cnt", eval_cnt, m_cnt);
      if (m_ov) begin
        e = exp_q[0];
        check("mon_out_x", out_x, e[N_OUT +: N_IN]);
        check("mon_out_f", out_f, e[N_OUT-1:0]);
        check("mon_out_last", out_last, e[EW-1]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          m_cnt++;
          if (e[EW-1]) m_sweep = 0;
        end
      end
      if (cfg_valid && m_cfg_ready && (int'(cfg_idx) < N_OUT)) m_tt[cfg_idx] = cfg_tt;
      if (sweep_start && !m_ov && !cfg_valid && !(in_valid && m_in_ready)) begin
        m_sweep = 1;
        for (int k = 0; k < DEPTH; k++) begin
          exp_q.push_back({(k == DEPTH - 1), N_IN'(k), model_f(N_IN'(k))});
        end
      end else if (in_valid && m_in_ready) begin
        exp_q.push_back({1'b0, in_x, model_f(in_x)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [DEPTH-1:0] tt);
    bit ok = 0;
    tick();
    cfg_valid = 1; cfg_idx = idx; cfg_tt = tt;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1; break; end
    end
    check("cfg_accept", ok, 1);
    tick();
    cfg_valid = 0;
  endtask

  task automatic stream_check(input string name, input logic [N_IN-1:0] x,
                              input logic [N_OUT-1:0] f);
    tick();
    in_valid = 1; in_x = x; out_ready = 1;
    @(negedge clk);
    check({name, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 0;
    @(negedge clk);
    check({name, "_out_valid"}, out_valid, 1);
    check({name, "_out_x"}, out_x, x);
    check({name, "_out_f"}, out_f, f);
  endtask

  typedef struct {
    logic [N_IN-1:0]  x;
    logic [N_OUT-1:0] f;
  } vec_t;
  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int unsigned base;
    int          last_seen;
    bit          found;
    int          r;

    cfg_valid = 0; cfg_idx = '0; cfg_tt = '0; in_valid = 0; in_x = '0;
    sweep_start = 0; out_ready = 1;

    // Tables: 0=x0, 1=x2^x3, 2=x3, 3=AND, 4=parity, 5=NOR. Expected f hand-derived.
    vecs[0] = '{4'd0,  6'h20};
    vecs[1] = '{4'd4,  6'h12};
    vecs[2] = '{4'd12, 6'h04};
    vecs[3] = '{4'd15, 6'h0D};
    vecs[4] = '{4'd5,  6'h03};
    vecs[5] = '{4'd9,  6'h07};
    vecs[6] = '{4'd7,  6'h13};

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_f", out_f, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_eval_cnt", eval_cnt, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    cfg_write(3'd0, 16'hAAAA);
    cfg_write(3'd1, 16'h0FF0);
    cfg_write(3'd2, 16'hFF00);
    cfg_write(3'd3, 16'h8000);
    cfg_write(3'd4, 16'h6996);
    cfg_write(3'd5, 16'h0001);
    cfg_write(3'd7, 16'hFFFF);   // out of range: must leave tables 0..5 alone

    for (int i = 0; i < 7; i++) stream_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].f);

    // Backpressure on a streamed result.
    tick();
    base = m_cnt;
    out_ready = 0; in_valid = 1; in_x = 4'd5;
    tick();
    in_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_x", out_x, 5);
      check("bp_out_f", out_f, 6'h03);
    end
    tick();
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    check("bp_eval_cnt", eval_cnt, base + 1);
    check("bp_drained", out_valid, 0);

    // Table write and vector in the same IDLE cycle: write wins, vector sees new table.
    tick();
    cfg_valid = 1; cfg_idx = 3'd5; cfg_tt = 16'h0000; in_valid = 1; in_x = 4'd0;
    @(negedge clk);
    check("sim_in_ready", in_ready, 0);
    check("sim_cfg_ready", cfg_ready, 1);
    tick();
    cfg_valid = 0;
    @(negedge clk);
    check("sim_in_ready_next", in_ready, 1);
    tick();
    in_valid = 0;
    @(negedge clk);
    check("sim_out_valid", out_valid, 1);
    check("sim_out_f", out_f, 6'h00);

    // Exhaustive sweep at full throughput.
    tick();
    base = m_cnt;
    sweep_start = 1;
    tick();
    sweep_start = 0;
    last_seen = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("sw_out_valid", out_valid, 1);
      check("sw_out_x", out_x, i);
      check("sw_out_f0", out_f[0], i % 2);
      check("sw_out_last", out_last, (i == DEPTH - 1));
      check("sw_busy", busy, 1);
      if (i == 0) check("sw_state", 32'(dbg_state), 32'(ST_SWEEP));
      if (out_last) last_seen++;
    end
    @(negedge clk);
    check("sw_busy_end", busy, 0);
    check("sw_out_valid_end", out_valid, 0);
    check("sw_eval_cnt", eval_cnt, base + DEPTH);
    check("sw_last_count", last_seen, 1);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      tick();
      r = $urandom_range(0, 99);
      out_ready   = ($urandom_range(0, 3) != 0);
      sweep_start = (r < 3);
      in_valid    = (r >= 3) && ($urandom_range(0, 1) == 1);
      in_x        = N_IN'($urandom_range(0, DEPTH - 1));
      cfg_valid   = (r >= 3) && (r < 12);
      cfg_idx     = 3'($urandom_range(0, 7));
      cfg_tt      = DEPTH'($urandom_range(0, 65535));
    end
    tick();
    sweep_start = 0; in_valid = 0; cfg_valid = 0; out_ready = 1;
    found = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin found = 1; break; end
    end
    check("rand_drain", found, 1);

    // Reset in the middle of a sweep.
    tick();
    sweep_start = 1;
    tick();
    sweep_start = 0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid && out_x == 4'd7) begin found = 1; break; end
    end
    check("mr_find7", found, 1);
    rst_n = 0;
    #1;
    check("mr_out_valid", out_valid, 0);
    check("mr_out_last", out_last, 0);
    check("mr_eval_cnt", eval_cnt, 0);
    check("mr_busy", busy, 0);
    check("mr_out_f", out_f, 0);
    check("mr_out_x", out_x, 0);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("mr_cfg_ready", cfg_ready, 1);
    stream_check("mr_zero15", 4'd15, 6'h00);
    stream_check("mr_zero0", 4'd0, 6'h00);

    cfg_write(3'd0, 16'hAAAA);
    tick();
    sweep_start = 1;
    tick();
    sweep_start = 0;
    @(negedge clk);
    check("rs_out_valid", out_valid, 1);
    check("rs_out_x", out_x, 0);
    found = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) begin found = 1; break; end
    end
    check("rs_done", found, 1);
    check("rs_eval_cnt", eval_cnt, 2 + DEPTH);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
